bcd_seq_converter: RTL and testbench
====================================

Name: bcd_seq_converter

Overview:
- Multi-cycle binary-to-BCD conversion controller using the shift-add-3 (double-dabble) algorithm.
- Replaces wide combinational divide/modulo digit extraction with one adjust-and-shift step per clock.
- Sits between a binary value source and the per-digit 7-segment decoders.
- Handshake: start/busy/done. Results are held until the next conversion completes.

Parameters:
- N, 10, binary input width in bits (N >= 1).
- DIGITS, 4, number of BCD digits produced (DIGITS >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only while busy=0.
- bin_in  input  N  unsigned binary operand; sampled on the edge that accepts start.
- busy  output  1  high from the accept edge until the conversion returns to IDLE.
- done  output  1  one-cycle pulse; bcd_out is updated on the same edge.
- valid  output  1  set by the first done; cleared only by reset.
- ovf  output  1  last accepted bin_in was >= 10^DIGITS; held with bcd_out.
- bcd_out  output  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k], digit 0 = units.
- blank  output  DIGITS  leading-zero mask; bit k=1 means digit k is a leading zero. Bit 0 is always 0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, valid=0, ovf=0, bcd_out=0, blank=0, internal counter and scratch=0. Applies immediately, including mid-conversion. The aborted conversion produces no done, and bcd_out is not partially updated.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - bin_reg <= bin_in; scratch <= 0; cnt <= 0.
  - ovf_pend <= (bin_in >= 10^DIGITS), compared at full width.
  - busy <= 1; go to SHIFT. With start=0, stay in IDLE.
- SHIFT, each edge:
  - For every scratch digit >= 5, add 3 (4-bit digit, no carry out).
  - Then shift {scratch, bin_reg} left by 1; the bin_reg MSB enters scratch bit 0.
  - cnt <= cnt+1. After the edge that performs shift N (cnt reaches N-1 before the edge), go to DONE.
  - Counter width is clog2(N+1).
- DONE, next edge:
  - bcd_out <= ovf_pend ? all digits 9 : scratch; ovf <= ovf_pend; blank updated from the new value; done <= 1; valid <= 1.
  - busy <= 0; go to IDLE.
- done falls on the following edge. done and busy=0 become visible after edge E0+N+1, so total latency is N+1 clocks from the accept edge.
- busy is 1 in SHIFT and DONE and 0 in IDLE. start is ignored while busy=1 and is never queued.
- If start is held high continuously, it is accepted again on the edge where done is visible. Conversions repeat every N+2 clocks.
- Blank rule: blank[k]=1 when digits k..DIGITS-1 are all 0, for k >= 1. When ovf=1, blank=0.
- bin_in changes after the accept edge do not affect the running conversion.
- Widths: scratch is 4*DIGITS bits. Bits shifted out of the top digit are discarded; that case is covered by the ovf saturation.

Decomposition:
- Shared package holds:
  - state enum (IDLE, SHIFT, DONE)
  - BCD_W=4
  - ADJ_THRESH=5, ADJ_ADD=3
  - constant function pow10(DIGITS) for the overflow limit
  - clog2 helper
- One combinational sub-module, bcd_adjust_shift. Inputs: scratch, bin_reg. Outputs: the next scratch and next bin_reg for one iteration. It is instantiated once, and the controller FSM, counter and output registers surround it.

Test Plan:
- Reset, then bin_in=0 with start pulse -> done after N+1 clocks; bcd_out=0x0000, blank=4'b1110, ovf=0, valid=1.
- bin_in=1023 (N=10) -> bcd_out=0x1023, blank=0000. Then bin_in=255 -> bcd_out=0x0255, blank=1000. done pulses are exactly 1 cycle wide, 12 cycles apart when start is held high.
- Start pulsed at cycles 3 and 7 after accept, with bin_in changed each time -> ignored; the result matches the originally sampled value and only one done pulse occurs.
- rst_n dropped at SHIFT cycle 5 -> all outputs 0 immediately with no done. A new start with bin_in=42 gives 0x0042.
- N=14, DIGITS=4, bin_in=12345 -> bcd_out=0x9999, ovf=1, blank=0. Then bin_in=9999 -> 0x9999, ovf=0.
- N=10, DIGITS=3, bin_in=999 -> 0x999, ovf=0; bin_in=1000 -> 0x999, ovf=1.

Source files
------------

// File: rtl/bcd_seq_converter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_seq_converter_pkg
// Shared types, constants and helper functions for the sequential
// binary-to-BCD (double-dabble) converter.
//   state_e    : controller FSM states
//   BCD_W      : bits per BCD digit
//   ADJ_THRESH : digit value at or above which the add-3 correction applies
//   ADJ_ADD    : correction added before each shift
//   LIMIT_W    : width used for the full-width overflow comparison
//   pow10()    : 10^digits, used for the overflow limit
//   clog2()    : ceiling log2, used to size the iteration counter
// -----------------------------------------------------------------------------
package bcd_seq_converter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int         BCD_W      = 4;
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    // Operands up to LIMIT_W bits and limits up to 10^38 are compared exactly.
    localparam int LIMIT_W = 128;

    function automatic logic [LIMIT_W-1:0] pow10(input int digits);
        logic [LIMIT_W-1:0] result;
        result = LIMIT_W'(1);
        for (int i = 0; i < digits; i++) begin
            result = result * LIMIT_W'(10);
        end
        return result;
    endfunction

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/bcd_seq_converter_adjust_shift.sv
// -----------------------------------------------------------------------------
// bcd_adjust_shift
// One combinational double-dabble iteration: every scratch digit >= 5 gets +3
// (4-bit wrap, no carry into the next digit), then {scratch, bin} shifts left
// by one so the bin MSB enters scratch bit 0.
//   scratch_i : current BCD scratch, 4*DIGITS bits
//   bin_i     : current binary shift register, N bits
//   scratch_o : scratch after adjust and shift
//   bin_o     : binary register after shift (LSB filled with 0)
// -----------------------------------------------------------------------------
module bcd_adjust_shift
    import bcd_seq_converter_pkg::*;
#(
    parameter int N      = 10,
    parameter int DIGITS = 4
) (
    input  logic [BCD_W*DIGITS-1:0] scratch_i,
    input  logic [N-1:0]            bin_i,
    output logic [BCD_W*DIGITS-1:0] scratch_o,
    output logic [N-1:0]            bin_o
);

    localparam int SW = BCD_W * DIGITS;

    logic [SW-1:0]   adjusted;
    logic [SW+N-1:0] shifted;

    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_i[k*BCD_W +: BCD_W] >= ADJ_THRESH) begin
                adjusted[k*BCD_W +: BCD_W] = scratch_i[k*BCD_W +: BCD_W] + ADJ_ADD;
            end else begin
                adjusted[k*BCD_W +: BCD_W] = scratch_i[k*BCD_W +: BCD_W];
            end
        end
    end

    // Shifting the concatenation handles N=1 without a special case; the
    // bit leaving the top digit is dropped and covered by ovf saturation.
    assign shifted   = {adjusted, bin_i} << 1;
    assign scratch_o = shifted[SW+N-1:N];
    assign bin_o     = shifted[N-1:0];

endmodule

// File: rtl/bcd_seq_converter.sv
// -----------------------------------------------------------------------------
// bcd_seq_converter
// Multi-cycle binary-to-BCD converter, one adjust-and-shift step per clock.
// Latency is N+1 clocks from the accept edge; results are held until the next
// conversion completes.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : conversion request, sampled only while idle
//   bin_in  : unsigned operand, captured on the accept edge
//   busy    : high while a conversion is in progress
//   done    : one-cycle pulse coincident with the bcd_out update
//   valid   : sticky after the first done, cleared only by reset
//   ovf     : last operand was >= 10^DIGITS (bcd_out saturated to all 9s)
//   bcd_out : packed BCD, digit 0 (units) in bits [3:0]
//   blank   : leading-zero mask, bit k set when digits k..DIGITS-1 are zero
// -----------------------------------------------------------------------------
module bcd_seq_converter
    import bcd_seq_converter_pkg::*;
#(
    parameter int N      = 10,
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [N-1:0]            bin_in,
    output logic                    busy,
    output logic                    done,
    output logic                    valid,
    output logic                    ovf,
    output logic [BCD_W*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]       blank
);

    localparam int                 SW        = BCD_W * DIGITS;
    localparam int                 CNT_W     = clog2(N + 1);
    localparam logic [LIMIT_W-1:0] OVF_LIMIT = pow10(DIGITS);
    localparam logic [SW-1:0]      ALL_NINES = {DIGITS{4'h9}};

    state_e state_q, state_d;

    logic [N-1:0]      bin_q, bin_d;
    logic [SW-1:0]     scratch_q, scratch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic [SW-1:0]     bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;

    logic [SW-1:0]     step_scratch;
    logic [N-1:0]      step_bin;
    logic [DIGITS-1:0] blank_calc;
    logic              zero_above;
    logic              last_shift;
    logic              in_ovf;

    bcd_adjust_shift #(
        .N      (N),
        .DIGITS (DIGITS)
    ) u_adjust_shift (
        .scratch_i (scratch_q),
        .bin_i     (bin_q),
        .scratch_o (step_scratch),
        .bin_o     (step_bin)
    );

    assign last_shift = (cnt_q == CNT_W'(N - 1));
    assign in_ovf     = (LIMIT_W'(bin_in) >= OVF_LIMIT);

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy    = (state_q != ST_IDLE);
        done    = done_q;
        valid   = valid_q;
        ovf     = ovf_q;
        bcd_out = bcd_q;
        blank   = blank_q;
    end

    // Leading-zero mask of the finished scratch value; scanned from the top
    // digit down so each bit reflects "this digit and everything above is 0".
    always_comb begin
        blank_calc = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above    = zero_above & (scratch_q[k*BCD_W +: BCD_W] == 4'd0);
            blank_calc[k] = zero_above;
        end
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        blank_d    = blank_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d      = bin_in;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    ovf_pend_d = in_ovf;
                end
            end
            ST_SHIFT: begin
                scratch_d = step_scratch;
                bin_d     = step_bin;
                cnt_d     = cnt_q + CNT_W'(1);
            end
            ST_DONE: begin
                bcd_d   = ovf_pend_q ? ALL_NINES : scratch_q;
                ovf_d   = ovf_pend_q;
                blank_d = ovf_pend_q ? '0 : blank_calc;
                done_d  = 1'b1;
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: every register, scratch included, is cleared by the async reset so
    // an aborted conversion leaves no residue visible after reset releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            blank_q    <= '0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            blank_q    <= blank_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_seq_converter
// Directed bench for bcd_seq_converter. Three instances cover the default
// configuration (N=10, DIGITS=4), a wider operand that can overflow
// (N=14, DIGITS=4) and a narrower display (N=10, DIGITS=3).
// -----------------------------------------------------------------------------
module tb_bcd_seq_converter;

    logic clk;
    logic rst_n;

    // instance A: N=10, DIGITS=4
    logic        start_a;
    logic [9:0]  bin_a;
    logic        busy_a, done_a, valid_a, ovf_a;
    logic [15:0] bcd_a;
    logic [3:0]  blank_a;

    // instance B: N=14, DIGITS=4
    logic        start_b;
    logic [13:0] bin_b;
    logic        busy_b, done_b, valid_b, ovf_b;
    logic [15:0] bcd_b;
    logic [3:0]  blank_b;

    // instance C: N=10, DIGITS=3
    logic        start_c;
    logic [9:0]  bin_c;
    logic        busy_c, done_c, valid_c, ovf_c;
    logic [11:0] bcd_c;
    logic [2:0]  blank_c;

    int checks;
    int failures;

    bcd_seq_converter #(.N(10), .DIGITS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
        .busy(busy_a), .done(done_a), .valid(valid_a), .ovf(ovf_a),
        .bcd_out(bcd_a), .blank(blank_a)
    );

    bcd_seq_converter #(.N(14), .DIGITS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
        .busy(busy_b), .done(done_b), .valid(valid_b), .ovf(ovf_b),
        .bcd_out(bcd_b), .blank(blank_b)
    );

    bcd_seq_converter #(.N(10), .DIGITS(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .bin_in(bin_c),
        .busy(busy_c), .done(done_c), .valid(valid_c), .ovf(ovf_c),
        .bcd_out(bcd_c), .blank(blank_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; return 1 ns after the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic sel_done(input int sel);
        case (sel)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    task automatic drive(input int sel, input logic s, input logic [13:0] v);
        case (sel)
            0:       begin start_a = s; bin_a = v[9:0]; end
            1:       begin start_b = s; bin_b = v;      end
            default: begin start_c = s; bin_c = v[9:0]; end
        endcase
    endtask

    // One pulsed conversion on the selected instance, with latency and
    // result checks. Bound of 40 cycles on the done wait.
    task automatic run(input int sel, input string tag, input logic [13:0] value,
                       input logic [15:0] exp_bcd, input logic [3:0] exp_blank,
                       input logic exp_ovf, input int exp_lat);
        int cyc;
        logic seen;
        drive(sel, 1'b1, value);
        step(1);
        drive(sel, 1'b0, value);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            step(1);
            cyc++;
            seen = sel_done(sel);
        end
        check({tag, "_done_seen"}, 64'(seen), 64'(1));
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        case (sel)
            0: begin
                check({tag, "_bcd"}, 64'(bcd_a), 64'(exp_bcd));
                check({tag, "_blank"}, 64'(blank_a), 64'(exp_blank));
                check({tag, "_ovf"}, 64'(ovf_a), 64'(exp_ovf));
                check({tag, "_valid"}, 64'(valid_a), 64'(1));
                check({tag, "_busy"}, 64'(busy_a), 64'(0));
            end
            1: begin
                check({tag, "_bcd"}, 64'(bcd_b), 64'(exp_bcd));
                check({tag, "_blank"}, 64'(blank_b), 64'(exp_blank));
                check({tag, "_ovf"}, 64'(ovf_b), 64'(exp_ovf));
                check({tag, "_valid"}, 64'(valid_b), 64'(1));
            end
            default: begin
                check({tag, "_bcd"}, 64'(bcd_c), 64'(exp_bcd[11:0]));
                check({tag, "_blank"}, 64'(blank_c), 64'(exp_blank[2:0]));
                check({tag, "_ovf"}, 64'(ovf_c), 64'(exp_ovf));
                check({tag, "_valid"}, 64'(valid_c), 64'(1));
            end
        endcase
        step(1);
        check({tag, "_done_width"}, 64'(sel_done(sel)), 64'(0));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int gap;
        int dones;
        logic seen;
        logic [15:0] held_bcd;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start_a  = 1'b0; bin_a = '0;
        start_b  = 1'b0; bin_b = '0;
        start_c  = 1'b0; bin_c = '0;

        // ---- reset state ----
        step(2);
        check("rst_busy",  64'(busy_a),  64'(0));
        check("rst_done",  64'(done_a),  64'(0));
        check("rst_valid", 64'(valid_a), 64'(0));
        check("rst_ovf",   64'(ovf_a),   64'(0));
        check("rst_bcd",   64'(bcd_a),   64'(0));
        check("rst_blank", 64'(blank_a), 64'(0));
        rst_n = 1'b1;
        step(2);
        check("idle_busy", 64'(busy_a), 64'(0));

        // ---- basic conversions, N=10, DIGITS=4 ----
        run(0, "zero", 14'd0,   16'h0000, 4'b1110, 1'b0, 11);
        run(0, "v999", 14'd999, 16'h0999, 4'b1000, 1'b0, 11);

        // ---- start held high: 1023 then 255, repeat period N+2 ----
        bin_a   = 10'd1023;
        start_a = 1'b1;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            step(1);
            cyc++;
            seen = done_a;
        end
        check("held1_done_seen", 64'(seen), 64'(1));
        check("held1_bcd",   64'(bcd_a),   64'h1023);
        check("held1_blank", 64'(blank_a), 64'(4'b0000));
        bin_a = 10'd255;
        step(1);
        check("held1_done_width", 64'(done_a), 64'(0));
        check("held2_accepted",   64'(busy_a), 64'(1));
        gap  = 1;
        seen = 1'b0;
        while (!seen && gap < 40) begin
            step(1);
            gap++;
            seen = done_a;
        end
        start_a = 1'b0;
        check("held2_done_seen", 64'(seen), 64'(1));
        check("held_period", 64'(gap), 64'(12));
        check("held2_bcd",   64'(bcd_a),   64'h0255);
        check("held2_blank", 64'(blank_a), 64'(4'b1000));
        step(1);
        check("held2_done_width", 64'(done_a), 64'(0));
        step(2);
        check("held_stop_idle", 64'(busy_a), 64'(0));

        // ---- start pulses while busy are ignored ----
        bin_a   = 10'd500;
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        dones    = 0;
        held_bcd = '0;
        for (int c = 1; c <= 24; c++) begin
            step(1);
            if (done_a) begin
                dones++;
                held_bcd = bcd_a;
            end
            if (c == 3) begin
                start_a = 1'b1; bin_a = 10'd77;
            end else if (c == 7) begin
                start_a = 1'b1; bin_a = 10'd321;
            end else begin
                start_a = 1'b0;
            end
        end
        check("ignore_done_count", 64'(dones), 64'(1));
        check("ignore_bcd", 64'(held_bcd), 64'h0500);
        check("ignore_blank", 64'(blank_a), 64'(4'b1000));

        // ---- asynchronous reset in the middle of SHIFT ----
        bin_a   = 10'd700;
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy",  64'(busy_a),  64'(0));
        check("abort_done",  64'(done_a),  64'(0));
        check("abort_valid", 64'(valid_a), 64'(0));
        check("abort_bcd",   64'(bcd_a),   64'(0));
        check("abort_blank", 64'(blank_a), 64'(0));
        check("abort_ovf",   64'(ovf_a),   64'(0));
        step(2);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            step(1);
            if (done_a) dones++;
        end
        check("abort_no_done", 64'(dones), 64'(0));
        check("abort_bcd_kept", 64'(bcd_a), 64'(0));
        run(0, "after_rst", 14'd42, 16'h0042, 4'b1100, 1'b0, 11);

        // ---- N=14, DIGITS=4 overflow saturation ----
        run(1, "b_ovf",  14'd12345, 16'h9999, 4'b0000, 1'b1, 15);
        run(1, "b_9999", 14'd9999,  16'h9999, 4'b0000, 1'b0, 15);
        run(1, "b_10000", 14'd10000, 16'h9999, 4'b0000, 1'b1, 15);

        // ---- N=10, DIGITS=3 boundary ----
        run(2, "c_999",  14'd999,  16'h0999, 4'b0000, 1'b0, 11);
        run(2, "c_1000", 14'd1000, 16'h0999, 4'b0000, 1'b1, 11);
        run(2, "c_5",    14'd5,    16'h0005, 4'b0110, 1'b0, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
